// File: rtl/eth_rs_rx_link_fault.sv
// -----------------------------------------------------------------------------
// eth_rs_rx_link_fault
//
// Receive-side Reconciliation Sublayer link-fault monitor for 10GBASE-R.
// It sits directly behind the PCS receive path. It watches the 8-lane XGMII
// stream for Sequence ordered sets (local / remote fault) and runs the
// link-fault state machine. The XGMII word is passed on through one register
// stage.
//
// Each 64-bit word holds two 4-lane columns. Column A is lanes 0-3 and
// column B is lanes 4-7. Both columns are evaluated in the same cycle: A is
// applied first, and B then works on the state that A produced.
//
// Ports:
//   i_clk              core clock
//   i_reset            asynchronous, active-high reset
//   i_clk_en           PCS data-valid qualifier; state advances only when high
//   i_xgmii_ctrl[7:0]  per-lane control flags from the PCS
//   i_xgmii_data[63:0] per-lane data from the PCS (lane n = bits 8n+7:8n)
//   o_xgmii_ctrl[7:0]  registered pass-through of i_xgmii_ctrl
//   o_xgmii_data[63:0] registered pass-through of i_xgmii_data
//   o_link_status[1:0] 00 = OK, 01 = LOCAL_FAULT, 10 = REMOTE_FAULT
//   o_fault_change     one-cycle pulse whenever o_link_status changes
//
// Optional build macro ETH_RS_RX_FAULT_STATS_EN adds two further outputs:
//   o_local_fault_cnt[15:0]  saturating count of entries into LOCAL_FAULT
//   o_remote_fault_cnt[15:0] saturating count of entries into REMOTE_FAULT
// -----------------------------------------------------------------------------

package eth_pcs_params;
  localparam int N_CHANNELS = 8;
  localparam int W_BYTE     = 8;
endpackage

module eth_rs_rx_link_fault
  import eth_pcs_params::*;
#(
  parameter int SEQ_THRESH = 4,
  parameter int COL_THRESH = 128
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clk_en,
  input  logic [N_CHANNELS-1:0]        i_xgmii_ctrl,
  input  logic [N_CHANNELS*W_BYTE-1:0] i_xgmii_data,
  output logic [N_CHANNELS-1:0]        o_xgmii_ctrl,
  output logic [N_CHANNELS*W_BYTE-1:0] o_xgmii_data,
  output logic [1:0]                   o_link_status,
  output logic                         o_fault_change
`ifdef ETH_RS_RX_FAULT_STATS_EN
  ,
  output logic [15:0]                  o_local_fault_cnt,
  output logic [15:0]                  o_remote_fault_cnt
`endif
);

  localparam int SEQ_W = (SEQ_THRESH > 1) ? $clog2(SEQ_THRESH) : 1;
  localparam logic [N_CHANNELS*W_BYTE-1:0] IDLE_DATA = {N_CHANNELS{8'h07}};

  // The link state uses the same encoding as the sequence type, so a
  // detected set type can be copied straight into the status.
  typedef enum logic [1:0] {
    LINK_OK     = 2'b00,
    LINK_LOCAL  = 2'b01,
    LINK_REMOTE = 2'b10
  } link_t;

  typedef struct packed {
    link_t            status;
    link_t            last_seq;
    logic [SEQ_W-1:0] seq_cnt;
    logic [7:0]       col_cnt;
  } mon_t;

  mon_t                         mon_q, mon_d, mon_a;
  logic [N_CHANNELS-1:0]        ctrl_q, ctrl_d;
  logic [N_CHANNELS*W_BYTE-1:0] data_q, data_d;
  logic                         fault_change_q, fault_change_d;

  // Classify one 4-lane column. Only a Sequence set that starts on the
  // column's first lane is recognised. A 0x9C that starts anywhere else
  // has the wrong ctrl pattern for this column and falls through as normal.
  function automatic link_t decode_column(input logic [3:0]  ctrl,
                                          input logic [31:0] data);
    decode_column = LINK_OK;
    if (ctrl == 4'b0001 && data[7:0] == 8'h9C &&
        data[15:8] == 8'h00 && data[23:16] == 8'h00) begin
      if (data[31:24] == 8'h01) begin
        decode_column = LINK_LOCAL;
      end else if (data[31:24] == 8'h02) begin
        decode_column = LINK_REMOTE;
      end
    end
  endfunction

  // Apply one column to the monitor state. The first set of a new type
  // restarts the run with seq_cnt = 0. A fault is therefore declared when
  // seq_cnt reaches SEQ_THRESH-1, which is the SEQ_THRESH-th consecutive set.
  function automatic mon_t step_column(input mon_t cur, input link_t seq_type);
    mon_t nxt;
    nxt = cur;
    if (seq_type != LINK_OK) begin
      nxt.col_cnt = '0;
      if (seq_type == cur.last_seq) begin
        if (cur.seq_cnt < SEQ_W'(SEQ_THRESH - 1)) begin
          nxt.seq_cnt = cur.seq_cnt + 1'b1;
        end
        if (nxt.seq_cnt == SEQ_W'(SEQ_THRESH - 1)) begin
          nxt.status = seq_type;
        end
      end else begin
        nxt.last_seq = seq_type;
        nxt.seq_cnt  = '0;
      end
    end else begin
      if (cur.col_cnt != 8'hFF) begin
        nxt.col_cnt = cur.col_cnt + 8'd1;
      end
      if (nxt.col_cnt == 8'(COL_THRESH)) begin
        nxt.seq_cnt  = '0;
        nxt.last_seq = LINK_OK;
        nxt.status   = LINK_OK;
        nxt.col_cnt  = '0;
      end
    end
    return nxt;
  endfunction

  // Next-state logic. Nothing moves unless the PCS marks the word as valid.
  // Column B is chained on the result of column A, so two sets that arrive
  // in one word both count.
  always_comb begin
    ctrl_d         = ctrl_q;
    data_d         = data_q;
    mon_a          = mon_q;
    mon_d          = mon_q;
    fault_change_d = 1'b0;
    if (i_clk_en) begin
      ctrl_d         = i_xgmii_ctrl;
      data_d         = i_xgmii_data;
      mon_a          = step_column(mon_q,
                                   decode_column(i_xgmii_ctrl[3:0], i_xgmii_data[31:0]));
      mon_d          = step_column(mon_a,
                                   decode_column(i_xgmii_ctrl[7:4], i_xgmii_data[63:32]));
      fault_change_d = (mon_d.status != mon_q.status);
    end
  end

  // State and pass-through registers. Reset shows XGMII Idle on the output
  // and returns the link to OK.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q         <= '1;
      data_q         <= IDLE_DATA;
      mon_q          <= '{status: LINK_OK, last_seq: LINK_OK, seq_cnt: '0, col_cnt: '0};
      fault_change_q <= 1'b0;
    end else begin
      ctrl_q         <= ctrl_d;
      data_q         <= data_d;
      mon_q          <= mon_d;
      fault_change_q <= fault_change_d;
    end
  end

  assign o_xgmii_ctrl   = ctrl_q;
  assign o_xgmii_data   = data_q;
  assign o_link_status  = mon_q.status;
  assign o_fault_change = fault_change_q;

`ifdef ETH_RS_RX_FAULT_STATS_EN
  logic [15:0] local_cnt_q, local_cnt_d;
  logic [15:0] remote_cnt_q, remote_cnt_d;

  // Count entries into each fault state. An entry is a cycle where the next
  // status is that fault and the current status is not. Both counters stop
  // at 0xFFFF instead of wrapping.
  always_comb begin
    local_cnt_d  = local_cnt_q;
    remote_cnt_d = remote_cnt_q;
    if (mon_d.status == LINK_LOCAL && mon_q.status != LINK_LOCAL &&
        local_cnt_q != 16'hFFFF) begin
      local_cnt_d = local_cnt_q + 16'd1;
    end
    if (mon_d.status == LINK_REMOTE && mon_q.status != LINK_REMOTE &&
        remote_cnt_q != 16'hFFFF) begin
      remote_cnt_d = remote_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      local_cnt_q  <= '0;
      remote_cnt_q <= '0;
    end else begin
      local_cnt_q  <= local_cnt_d;
      remote_cnt_q <= remote_cnt_d;
    end
  end

  assign o_local_fault_cnt  = local_cnt_q;
  assign o_remote_fault_cnt = remote_cnt_q;
`else
  // Statistics disabled: no extra ports and no counters.
`endif

endmodule
